// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker: mode encodings, FSM states and the
// reference-function helper used by gate_sweep_ref.
package gate_sweep_pkg;

  localparam logic [1:0] MODE_NOR  = 2'd0;
  localparam logic [1:0] MODE_NAND = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_AND  = 2'd3;

  localparam int unsigned MaxN = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

  // vec is zero-extended to MaxN; bits at or above n are forced high for the AND-type reductions.
  function automatic logic expected(input logic [1:0] mode, input logic [MaxN-1:0] vec,
                                    input int unsigned n);
    logic [MaxN-1:0] vec_ones;
    expected = 1'b0;
    vec_ones = vec;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i >= n) vec_ones[i] = 1'b1;
    end
    case (mode)
      MODE_NOR:  expected = ~|vec;
      MODE_NAND: expected = ~&vec_ones;
      MODE_XOR:  expected = ^vec;
      MODE_AND:  expected = &vec_ones;
      default:   expected = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_sweep_ref.sv
// Combinational N-input reference gate selected by mode (NOR, NAND, XOR, AND).
module gate_sweep_ref
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [1:0]   mode_i,
  input  logic [N-1:0] vec_i,
  output logic         y_o
);

  logic [MaxN-1:0] vec_ext;

  assign vec_ext = MaxN'(vec_i);
  assign y_o     = expected(mode_i, vec_ext, N);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive clocked sweep of all N-bit vectors against a reference gate, counting mismatches.
// Optional first-mismatch capture is enabled by defining GATE_SWEEP_FAILCAP_EN.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned SETTLE = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic         dut_y_i,
  output logic [N-1:0] stim_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [N:0]   err_count_o,
  output logic [N-1:0] first_fail_o
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [N-1:0]    stim_q, stim_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      err_q, err_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            exp_y, mismatch, start_sweep, check_fire;

  gate_sweep_ref #(
    .N(N)
  ) u_ref (
    .mode_i(mode_q),
    .vec_i (stim_q),
    .y_o   (exp_y)
  );

  // Case inequality so an X/Z from the cell under test counts as a mismatch in simulation.
  assign mismatch = (dut_y_i !== exp_y);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stim_d      = stim_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    start_sweep = 1'b0;
    check_fire  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d     = StSettle;
          mode_d      = mode_i;
          stim_d      = '0;
          cnt_d       = CntLoad;
          err_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          start_sweep = 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCheck;
        else cnt_d = cnt_q - 1'b1;
      end
      StCheck: begin
        check_fire = 1'b1;
        err_d      = err_q + {{N{1'b0}}, mismatch};
        if (&stim_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = StSettle;
          stim_d  = stim_q + 1'b1;
          cnt_d   = CntLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= MODE_NOR;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GATE_SWEEP_FAILCAP_EN
  logic [N-1:0] first_fail_q, first_fail_d;

  always_comb begin
    first_fail_d = first_fail_q;
    if (start_sweep) first_fail_d = '0;
    else if (check_fire && mismatch && (err_q == '0)) first_fail_d = stim_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) first_fail_q <= '0;
    else first_fail_q <= first_fail_d;
  end

  assign first_fail_o = first_fail_q;
`else
  assign first_fail_o = '0;
`endif

  assign stim_o      = stim_q;
  assign busy_o      = (state_q == StSettle) || (state_q == StCheck);
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: N=2 and N=3 instances driven by small behavioural cells.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // N=2 instance
  logic       start = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic       dut_y;
  logic [1:0] stim;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_fail;
  int         kind = 0;  // 0 NOR cell, 1 stuck-at-0, 2 AND cell

  // N=3 instance
  logic       start3 = 1'b0;
  logic [1:0] mode3  = 2'd0;
  logic       dut3_y;
  logic [2:0] stim3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] first_fail3;

  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    dut_y = 1'b0;
    case (kind)
      0:       dut_y = ~|stim;
      1:       dut_y = 1'b0;
      2:       dut_y = &stim;
      default: dut_y = ^stim;
    endcase
  end

  assign dut3_y = ^stim3;

  gate_sweep_checker #(
    .N(2),
    .SETTLE(5)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mode_i      (mode),
    .dut_y_i     (dut_y),
    .stim_o      (stim),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_count_o (err_count),
    .first_fail_o(first_fail)
  );

  gate_sweep_checker #(
    .N(3),
    .SETTLE(5)
  ) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start3),
    .mode_i      (mode3),
    .dut_y_i     (dut3_y),
    .stim_o      (stim3),
    .busy_o      (busy3),
    .done_o      (done3),
    .pass_o      (pass3),
    .err_count_o (err3),
    .first_fail_o(first_fail3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge following the edge that accepted start.
  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [2:0] e_err, input logic e_pass,
                              input logic [1:0] e_ff);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_err"}, 32'(err_count), 32'(e_err));
    check_eq({tag, "_pass"}, 32'(pass), 32'(e_pass));
    check_eq({tag, "_ff"}, 32'(first_fail), 32'(e_ff));
  endtask

  logic [1:0] exp_ff_and;

  initial begin
`ifdef GATE_SWEEP_FAILCAP_EN
    exp_ff_and = 2'd3;
`else
    exp_ff_and = 2'd0;
`endif
    // Reset values
    wait_cyc(3);
    check_eq("rst_stim", 32'(stim), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_ff", 32'(first_fail), 32'd0);
    rst = 1'b0;
    wait_cyc(2);

    // Correct NOR cell: stim steps every 6 cycles, done after 24
    kind = 0;
    pulse_start(2'd0);
    check_eq("t1_stim0", 32'(stim), 32'd0);
    check_eq("t1_busy0", 32'(busy), 32'd1);
    check_eq("t1_done0", 32'(done), 32'd0);
    wait_cyc(6);
    check_eq("t1_stim1", 32'(stim), 32'd1);
    wait_cyc(6);
    check_eq("t1_stim2", 32'(stim), 32'd2);
    wait_cyc(6);
    check_eq("t1_stim3", 32'(stim), 32'd3);
    wait_cyc(5);
    check_eq("t1_done23", 32'(done), 32'd0);
    check_eq("t1_busy23", 32'(busy), 32'd1);
    wait_cyc(1);
    check_result("t1", 3'd0, 1'b1, 2'd0);
    check_eq("t1_stimhold", 32'(stim), 32'd3);

    // NOR reference, stuck-at-0 cell: only vector 0 mismatches
    kind = 1;
    pulse_start(2'd0);
    wait_cyc(24);
    check_result("t2", 3'd1, 1'b0, 2'd0);

    // NAND reference, AND cell: every vector mismatches
    kind = 2;
    pulse_start(2'd1);
    wait_cyc(24);
    check_result("t3", 3'd4, 1'b0, 2'd0);

    // AND reference, stuck-at-0 cell: only vector 3 mismatches
    kind = 1;
    pulse_start(2'd3);
    wait_cyc(24);
    check_result("t3b", 3'd1, 1'b0, exp_ff_and);

    // N=3 XOR sweep: 48 cycles
    @(negedge clk);
    mode3  = 2'd2;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_cyc(47);
    check_eq("t4_done47", 32'(done3), 32'd0);
    wait_cyc(1);
    check_eq("t4_done", 32'(done3), 32'd1);
    check_eq("t4_pass", 32'(pass3), 32'd1);
    check_eq("t4_err", 32'(err3), 32'd0);
    check_eq("t4_stim", 32'(stim3), 32'd7);

    // start and mode change mid-sweep are ignored
    kind = 0;
    pulse_start(2'd0);
    wait_cyc(9);
    start = 1'b1;
    mode  = 2'd1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(2);
    check_eq("t5_stim12", 32'(stim), 32'd2);
    wait_cyc(11);
    check_eq("t5_done23", 32'(done), 32'd0);
    wait_cyc(1);
    check_result("t5", 3'd0, 1'b1, 2'd0);

    // Asynchronous reset mid-sweep, then a clean sweep
    kind = 1;
    pulse_start(2'd0);
    wait_cyc(13);
    check_eq("t6_err_pre", 32'(err_count), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_stim", 32'(stim), 32'd0);
    check_eq("t6_err", 32'(err_count), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    kind = 0;
    pulse_start(2'd0);
    wait_cyc(23);
    check_eq("t6_done23", 32'(done), 32'd0);
    wait_cyc(1);
    check_result("t6", 3'd0, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
